// File: rtl/mux_rr_arbiter_pkg.sv
// Shared encodings and grant-decision helper for the two-requester
// round-robin packet arbiter.
package mux_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } arb_state_e;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } arb_prio_e;

    // Grant chosen from IDLE: a lone requester wins regardless of priority,
    // a tie goes to the side named by prio.
    function automatic arb_state_e grant_of(input logic a_v, input logic b_v,
                                            input arb_prio_e prio);
        arb_state_e g;
        g = ST_IDLE;
        if (a_v && b_v) begin
            g = (prio == PRIO_A) ? ST_GNT_A : ST_GNT_B;
        end else if (a_v) begin
            g = ST_GNT_A;
        end else if (b_v) begin
            g = ST_GNT_B;
        end
        return g;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// One-bit 2:1 multiplexer cell: out = sel ? b : a.
module mux_rr_arbiter_mux (
    output logic out,
    input  logic a,
    input  logic b,
    input  logic sel
);

    assign out = sel ? b : a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin packet arbiter: grant held for a full packet,
// payload steered through a bank of 1-bit mux cells into one output register.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             sel,
    output logic             busy
);

    arb_state_e       r_state;
    arb_prio_e        r_prio;
    logic             r_sel;
    logic             r_busy;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;

    logic [WIDTH-1:0] w_mux_data;
    logic             w_mux_last;
    logic             w_load;
    logic             w_beat_valid;
    logic             w_accept;
    arb_state_e       w_grant;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_data_mux
            mux_rr_arbiter_mux u_mux (
                .out (w_mux_data[gi]),
                .a   (a_data[gi]),
                .b   (b_data[gi]),
                .sel (r_sel)
            );
        end
    endgenerate

    mux_rr_arbiter_mux u_last_mux (
        .out (w_mux_last),
        .a   (a_last),
        .b   (b_last),
        .sel (r_sel)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign w_load       = !r_out_valid || out_ready;
    assign w_beat_valid = r_sel ? b_valid : a_valid;
    assign w_accept     = r_busy && w_load && w_beat_valid;
    assign w_grant      = grant_of(a_valid, b_valid, r_prio);

    assign a_ready   = (r_state == ST_GNT_A) && w_load;
    assign b_ready   = (r_state == ST_GNT_B) && w_load;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign sel       = r_sel;
    assign busy      = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_prio      <= PRIO_A;
            r_sel       <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux_data;
                r_out_last  <= w_mux_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_state <= w_grant;
                    r_sel   <= (w_grant == ST_GNT_B);
                    r_busy  <= (w_grant != ST_IDLE);
                end
                ST_GNT_A, ST_GNT_B: begin
                    // Release only on the accepted last beat; the served side loses priority.
                    if (w_accept && w_mux_last) begin
                        r_state <= ST_IDLE;
                        r_sel   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_prio  <= (r_state == ST_GNT_A) ? PRIO_B : PRIO_A;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sel   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: cycle checks in one initial block plus
// an output scoreboard fed with the expected beat order.
module tb_mux_rr_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, a_last, b_valid, b_last, out_ready;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_ready, b_ready, out_valid, out_last, sel, busy;
    logic [WIDTH-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH:0] sb_q[$];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .a_last    (a_last),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .b_last    (b_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sel       (sel),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic last, input logic [WIDTH-1:0] data);
        sb_q.push_back({last, data});
    endtask

    // Output beats transfer at the next rising edge when valid & ready hold now.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [WIDTH:0] exp_beat;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_beat", {23'd0, out_last, out_data}, 32'h1ff);
            end else begin
                exp_beat = sb_q.pop_front();
                $display("[TB] out beat data=%02h last=%0d", out_data, out_last);
                chk("sb_beat", {23'd0, out_last, out_data}, {23'd0, exp_beat});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;

        // Scenario 1: reset with both valids high
        a_valid = 1'b1; b_valid = 1'b1;
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b0;

        // Scenario 2: single 3-beat A packet
        a_valid = 1'b1; a_data = 8'h11; a_last = 1'b0; push(1'b0, 8'h11);
        #1; chk("s2_idle_a_ready", a_ready, 0); chk("s2_idle_busy", busy, 0);
        step(); #1;
        chk("s2_grant_busy", busy, 1); chk("s2_grant_sel", sel, 0); chk("s2_grant_a_ready", a_ready, 1);
        step();
        a_data = 8'h22; push(1'b0, 8'h22); #1;
        chk("s2_beat1_valid", out_valid, 1); chk("s2_beat1_data", out_data, 8'h11);
        chk("s2_beat1_last", out_last, 0);
        step();
        a_data = 8'h33; a_last = 1'b1; push(1'b1, 8'h33); #1;
        chk("s2_beat2_data", out_data, 8'h22);
        step();
        a_valid = 1'b0; a_last = 1'b0; #1;
        chk("s2_beat3_data", out_data, 8'h33); chk("s2_beat3_last", out_last, 1);
        chk("s2_busy_fall", busy, 0);
        step();
        chk("s2_drained", out_valid, 0);
        // Prio is now B: a tie must go to B
        a_valid = 1'b1; b_valid = 1'b1;
        step();
        a_valid = 1'b0; b_valid = 1'b0; #1;
        chk("s2_prio_b_sel", sel, 1);

        // Scenario 3: round robin with both valid at reset release
        rst = 1'b1;
        a_valid = 1'b1; a_data = 8'hAA; a_last = 1'b1;
        b_valid = 1'b1; b_data = 8'hBB; b_last = 1'b1;
        for (int k = 0; k < 8; k++) push(1'b1, (k % 2 == 0) ? 8'hAA : 8'hBB);
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(); #1;
            chk("s3_busy", busy, 1);
            chk("s3_sel", sel, k % 2);
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        step(); step();

        // Scenario 4: backpressure during a B packet
        b_valid = 1'b1; b_data = 8'h01; b_last = 1'b0;
        push(1'b0, 8'h01); push(1'b1, 8'h02);
        step(); #1;
        chk("s4_b_ready", b_ready, 1);
        step();
        out_ready = 1'b0; b_data = 8'h02; b_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s4_stall_b_ready", b_ready, 0);
            chk("s4_stall_valid", out_valid, 1);
            chk("s4_stall_data", out_data, 8'h01);
            step();
        end
        out_ready = 1'b1; #1;
        chk("s4_resume_b_ready", b_ready, 1);
        step();
        b_valid = 1'b0; b_last = 1'b0; #1;
        chk("s4_last_data", out_data, 8'h02); chk("s4_last_flag", out_last, 1);
        step(); step();

        // Scenario 5: packet lock while B waits
        a_valid = 1'b1; a_data = 8'h51; a_last = 1'b0; push(1'b0, 8'h51);
        b_valid = 1'b1; b_data = 8'h61; b_last = 1'b1;
        step(); #1;
        chk("s5_grant_sel", sel, 0);
        step();
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s5_lock_sel", sel, 0);
            chk("s5_lock_b_ready", b_ready, 0);
            chk("s5_lock_busy", busy, 1);
            step();
        end
        a_valid = 1'b1; a_data = 8'h52; a_last = 1'b1; push(1'b1, 8'h52); push(1'b1, 8'h61);
        #1; chk("s5_a_ready", a_ready, 1);
        step();
        a_valid = 1'b0; a_last = 1'b0; #1;
        chk("s5_idle_b_ready", b_ready, 0);
        step(); #1;
        chk("s5_b_sel", sel, 1); chk("s5_b_ready", b_ready, 1);
        step();
        b_valid = 1'b0; b_last = 1'b0;
        step(); step();

        // Scenario 6: reset mid-packet, then a fresh B request
        a_valid = 1'b1; a_data = 8'h71; a_last = 1'b0;
        step(); #1;
        chk("s6_a_ready", a_ready, 1);
        step();
        rst = 1'b1; a_valid = 1'b0; a_data = 8'h72;
        step();
        rst = 1'b0; #1;
        chk("s6_rst_out_valid", out_valid, 0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_sel", sel, 0);
        b_valid = 1'b1; b_data = 8'h81; b_last = 1'b1; push(1'b1, 8'h81);
        #1; chk("s6_idle_b_ready", b_ready, 0);
        step(); #1;
        chk("s6_b_sel", sel, 1); chk("s6_b_ready", b_ready, 1);
        step();
        b_valid = 1'b0; b_last = 1'b0;
        step(); step(); step();

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
